// File: rtl/intra_tap_accumulator.sv
// intra_tap_accumulator: sums signed tap products into one rounded, shifted intra pel.
// Optional output clipping to [0, 2^BD-1] is enabled by defining CLIP_OUT_EN.
module intra_tap_accumulator #(
    parameter int NTAPS  = 4,
    parameter int PROD_W = 16,
    parameter int ACC_W  = 20,
    parameter int SHIFT  = 6,
    parameter int BD     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PROD_W-1:0] in_prod,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BD-1:0]            out_pel,
    output logic [2:0]               out_ntaps
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;

    localparam logic signed [ACC_W-1:0] RND  = ACC_W'(1 << (SHIFT - 1));
    localparam logic signed [ACC_W-1:0] PMAX = ACC_W'((1 << BD) - 1);
    localparam logic [2:0]              LAST = 3'(NTAPS - 1);

    logic [0:0]              state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [2:0]              cnt_q, cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic [BD-1:0]           out_pel_q, out_pel_d;
    logic [2:0]              out_ntaps_q, out_ntaps_d;

    logic                    accept;
    logic                    is_final;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] rnd;
    logic [BD-1:0]           pel;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign is_final  = in_last || (cnt_q == LAST);
    assign out_valid = out_valid_q;
    assign out_pel   = out_pel_q;
    assign out_ntaps = out_ntaps_q;

    // Sum, round and convert the current tap into a candidate pel.
    always_comb begin
        acc_base = (state_q == IDLE) ? '0 : acc_q;
        sum      = acc_base + ACC_W'(in_prod);
        rnd      = (sum + RND) >>> SHIFT;
`ifdef CLIP_OUT_EN
        if (rnd < 0)
            pel = '0;
        else if (rnd > PMAX)
            pel = BD'(PMAX);
        else
            pel = BD'(rnd);
`else
        pel = BD'(rnd);
`endif
    end

    // Next-state for the tap accumulator and the single output slot.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_pel_d   = out_pel_q;
        out_ntaps_d = out_ntaps_q;
        if (out_valid_q && out_ready)
            out_valid_d = 1'b0;
        if (accept) begin
            if (is_final) begin
                state_d     = IDLE;
                acc_d       = '0;
                cnt_d       = '0;
                out_valid_d = 1'b1;
                out_pel_d   = pel;
                out_ntaps_d = cnt_q + 3'd1;
            end else begin
                state_d = ACCUM;
                acc_d   = sum;
                cnt_d   = cnt_q + 3'd1;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_pel_q   <= '0;
            out_ntaps_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_pel_q   <= out_pel_d;
            out_ntaps_q <= out_ntaps_d;
        end
    end

endmodule

// File: tb/tb_intra_tap_accumulator.sv
// tb_intra_tap_accumulator: directed vectors for the intra tap accumulator.
// Expected pels follow the build: CLIP_OUT_EN defined selects clipped values.
module tb_intra_tap_accumulator;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_prod;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [7:0]         out_pel;
    logic [2:0]         out_ntaps;

    int n_vec = 0;
    int n_bad = 0;

`ifdef CLIP_OUT_EN
    localparam int OVF_PEL = 255;
    localparam int NEG_PEL = 0;
`else
    localparam int OVF_PEL = 246;
    localparam int NEG_PEL = 251;
`endif

    intra_tap_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pel   (out_pel),
        .out_ntaps (out_ntaps)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; the tap is accepted on the following posedge.
    task automatic tap(input int p, input bit l);
        chk("in_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_prod  = 16'(p);
        in_last  = l;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_prod  = '0;
    endtask

    task automatic chk_out(input string tag, input int pel, input int nt);
        chk({tag, "_valid"}, 32'(out_valid), 1);
        chk({tag, "_pel"}, 32'(out_pel), 32'(pel));
        chk({tag, "_ntaps"}, 32'(out_ntaps), 32'(nt));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #2;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_pel", 32'(out_pel), 0);
        chk("rst_ntaps", 32'(out_ntaps), 0);
        chk("rst_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 2-tap linear
        tap(6400, 0);
        chk("two_mid_valid", 32'(out_valid), 0);
        tap(3200, 1);
        chk_out("two", 150, 2);
        @(negedge clk);
        chk("two_clear", 32'(out_valid), 0);

        // 4-tap with out-of-range result
        tap(16065, 0);
        tap(16065, 0);
        tap(0, 0);
        tap(0, 1);
        chk_out("ovf", OVF_PEL, 4);

        // Negative result
        tap(-640, 0);
        tap(320, 1);
        chk_out("neg", NEG_PEL, 2);

        // No in_last: fourth tap ends the pel, fifth starts a new one
        tap(640, 0);
        tap(640, 0);
        tap(640, 0);
        tap(640, 0);
        chk_out("nolast", 40, 4);
        tap(3200, 1);
        chk_out("fifth", 50, 1);
        @(negedge clk);

        // Backpressure with a pending pel, then a no-bubble reload
        out_ready = 1'b0;
        tap(6400, 0);
        tap(3200, 1);
        chk_out("bp", 150, 2);
        in_valid = 1'b1;
        in_prod  = 16'sd640;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ready", 32'(in_ready), 0);
            chk_out("bp_hold", 150, 2);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk_out("nobubble", 10, 1);
        @(negedge clk);
        chk("nobubble_clear", 32'(out_valid), 0);

        // Idle gap mid-pel holds the partial sum
        tap(6400, 0);
        repeat (3) @(negedge clk);
        chk("gap_valid", 32'(out_valid), 0);
        tap(3200, 1);
        chk_out("gap", 150, 2);
        @(negedge clk);

        // Reset mid-pel discards the partial sum
        tap(6400, 0);
        tap(6400, 0);
        rst = 1'b1;
        #1;
        chk("rstmid_valid", 32'(out_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_none", 32'(out_valid), 0);
        tap(3200, 1);
        chk_out("rstmid", 50, 1);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
